// File: rtl/iob_dma_mc_pkg.sv
// Shared definitions for the multi-channel DMA burst scheduler.
//   chan_state_t : per-channel FSM encoding (IDLE -> ACTIVE -> DRAIN -> IDLE)
//   DIR_READ     : memory -> stream transfer
//   DIR_WRITE    : stream -> memory transfer
//   BOUNDARY_W   : log2 of the AXI address boundary a burst must not cross (4 KB)
package iob_dma_mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } chan_state_t;

    localparam logic DIR_READ   = 1'b0;
    localparam logic DIR_WRITE  = 1'b1;
    localparam int   BOUNDARY_W = 12;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/iob_dma_mc_chan.sv
// One DMA channel: descriptor latch, FSM, address/remaining/outstanding
// counters and the size of the next burst.
// Ports:
//   clk_i, cke_i, rst_i   clock, clock enable, sync active-high reset
//   cfg_valid_i/ready_o   descriptor handshake; addr/len/dir latched on accept
//   abort_i               abort request, honoured while ACTIVE
//   eligible_o            channel may be granted by the arbiter this cycle
//   grant_i               arbiter loaded this channel's burst into the command register
//   accept_i              downstream accepted this channel's command
//   cpl_i, cpl_err_i      burst completion for this channel, with error flag
//   burst_addr_o/len_o    next burst address and AXI length (beats - 1)
//   dir_o                 latched direction
//   busy_o, done_o, err_o channel status
module iob_dma_mc_chan
    import iob_dma_mc_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 24,
    parameter int BURST_W   = 8,
    parameter int MAX_OUTST = 4
) (
    input  logic               clk_i,
    input  logic               cke_i,
    input  logic               rst_i,
    input  logic               cfg_valid_i,
    output logic               cfg_ready_o,
    input  logic [ADDR_W-1:0]  cfg_addr_i,
    input  logic [LEN_W-1:0]   cfg_len_i,
    input  logic               cfg_dir_i,
    input  logic               abort_i,
    output logic               eligible_o,
    input  logic               grant_i,
    input  logic               accept_i,
    input  logic               cpl_i,
    input  logic               cpl_err_i,
    output logic [ADDR_W-1:0]  burst_addr_o,
    output logic [BURST_W-1:0] burst_len_o,
    output logic               dir_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int BW    = max_int(LEN_W, BOUNDARY_W + 1);
    localparam int OW    = $clog2(MAX_OUTST + 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);
    localparam logic [BW-1:0]     MAX_BEATS  = BW'(2 ** BURST_W);

    function automatic logic [BW-1:0] min3(input logic [BW-1:0] a,
                                           input logic [BW-1:0] b,
                                           input logic [BW-1:0] c);
        logic [BW-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    chan_state_t         state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [LEN_W-1:0]    rem_q;
    logic                dir_q;
    logic [OW-1:0]       outst_q, outst_d;
    logic                pend_q, done_q, err_q;
    logic [BOUNDARY_W:0] room_bytes;
    logic [BW-1:0]       room_words, beats;
    logic                cfg_fire, misaligned, cpl_take, drain_done, last_burst;

    // Words left before the next 4 KB page; a full page when addr[11:0] == 0.
    assign room_bytes = {1'b1, {BOUNDARY_W{1'b0}}} - {1'b0, addr_q[BOUNDARY_W-1:0]};
    assign room_words = BW'(room_bytes >> OFF_W);
    assign beats      = min3(BW'(rem_q), MAX_BEATS, room_words);
    assign last_burst = (BW'(rem_q) == beats);

    assign cfg_fire   = cfg_valid_i && (state_q == ST_IDLE);
    assign misaligned = (cfg_addr_i & ALIGN_MASK) != '0;
    assign cpl_take   = cpl_i && (outst_q != '0);
    // A command still sitting in the command register will become outstanding,
    // so the channel must not retire while one is pending.
    assign drain_done = (state_q == ST_DRAIN) && (outst_q == '0) && !pend_q;

    always_comb begin
        state_d    = state_q;
        eligible_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_fire && (cfg_len_i != '0) && !misaligned)
                    state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                // Abort masks eligibility in the same cycle so no new burst slips out.
                eligible_o = !abort_i && !pend_q && (outst_q < OW'(MAX_OUTST));
                if (abort_i || (accept_i && last_burst))
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_done)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        outst_d = outst_q;
        if (accept_i && !cpl_take)
            outst_d = outst_q + OW'(1);
        else if (!accept_i && cpl_take)
            outst_d = outst_q - OW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            outst_q <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (cke_i) begin
            state_q <= state_d;
            outst_q <= outst_d;
            if (grant_i)
                pend_q <= 1'b1;
            else if (accept_i)
                pend_q <= 1'b0;
            // Descriptors that never go ACTIVE still report completion.
            done_q <= cfg_fire && ((cfg_len_i == '0) || misaligned);
            if (cfg_fire)
                err_q <= misaligned && (cfg_len_i != '0);
            else if ((cpl_take && cpl_err_i) || ((state_q == ST_ACTIVE) && abort_i))
                err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (cfg_fire) begin
                addr_q <= cfg_addr_i;
                rem_q  <= cfg_len_i;
                dir_q  <= cfg_dir_i;
            end else if (accept_i) begin
                addr_q <= addr_q + (ADDR_W'(beats) << OFF_W);
                rem_q  <= rem_q - LEN_W'(beats);
            end
        end
    end

    assign cfg_ready_o  = (state_q == ST_IDLE);
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = done_q | drain_done;
    assign err_o        = err_q;
    assign burst_addr_o = addr_q;
    assign burst_len_o  = BURST_W'(beats - BW'(1));
    assign dir_o        = dir_q;

endmodule

// File: rtl/iob_dma_mc.sv
// Multi-channel DMA burst scheduler top: N_CH channel engines, a round-robin
// arbiter and a single AXI-style command register.
// Ports:
//   clk_i, cke_i, rst_i           clock, clock enable, sync active-high reset
//   cfg_valid_i/ready_o           per-channel descriptor handshake
//   cfg_addr_i/len_i/dir_i        packed per-channel descriptor fields
//   abort_i                       per-channel abort request
//   cmd_valid_o/ready_i           burst command handshake to the data engine
//   cmd_ch_o/addr_o/len_o/dir_o   burst command fields (len = beats - 1)
//   cpl_valid_i/ch_i/err_i        per-burst completion from the data engine
//   busy_o, done_o, err_o         per-channel status
module iob_dma_mc
    import iob_dma_mc_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 24,
    parameter int BURST_W   = 8,
    parameter int MAX_OUTST = 4,
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk_i,
    input  logic                   cke_i,
    input  logic                   rst_i,
    input  logic [N_CH-1:0]        cfg_valid_i,
    output logic [N_CH-1:0]        cfg_ready_o,
    input  logic [N_CH*ADDR_W-1:0] cfg_addr_i,
    input  logic [N_CH*LEN_W-1:0]  cfg_len_i,
    input  logic [N_CH-1:0]        cfg_dir_i,
    input  logic [N_CH-1:0]        abort_i,
    output logic                   cmd_valid_o,
    input  logic                   cmd_ready_i,
    output logic [CH_W-1:0]        cmd_ch_o,
    output logic [ADDR_W-1:0]      cmd_addr_o,
    output logic [BURST_W-1:0]     cmd_len_o,
    output logic                   cmd_dir_o,
    input  logic                   cpl_valid_i,
    input  logic [CH_W-1:0]        cpl_ch_i,
    input  logic                   cpl_err_i,
    output logic [N_CH-1:0]        busy_o,
    output logic [N_CH-1:0]        done_o,
    output logic [N_CH-1:0]        err_o
);

    logic [N_CH-1:0]    elig, grant, accept_vec, cpl_vec, ch_dir;
    logic [ADDR_W-1:0]  ch_addr [N_CH];
    logic [BURST_W-1:0] ch_len  [N_CH];
    logic [CH_W-1:0]    rr_ptr_q, sel_ch;
    logic               sel_found, load, accept;
    int                 idx;

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        iob_dma_mc_chan #(
            .ADDR_W    (ADDR_W),
            .DATA_W    (DATA_W),
            .LEN_W     (LEN_W),
            .BURST_W   (BURST_W),
            .MAX_OUTST (MAX_OUTST)
        ) u_chan (
            .clk_i        (clk_i),
            .cke_i        (cke_i),
            .rst_i        (rst_i),
            .cfg_valid_i  (cfg_valid_i[g]),
            .cfg_ready_o  (cfg_ready_o[g]),
            .cfg_addr_i   (cfg_addr_i[g*ADDR_W +: ADDR_W]),
            .cfg_len_i    (cfg_len_i[g*LEN_W +: LEN_W]),
            .cfg_dir_i    (cfg_dir_i[g]),
            .abort_i      (abort_i[g]),
            .eligible_o   (elig[g]),
            .grant_i      (grant[g]),
            .accept_i     (accept_vec[g]),
            .cpl_i        (cpl_vec[g]),
            .cpl_err_i    (cpl_err_i),
            .burst_addr_o (ch_addr[g]),
            .burst_len_o  (ch_len[g]),
            .dir_o        (ch_dir[g]),
            .busy_o       (busy_o[g]),
            .done_o       (done_o[g]),
            .err_o        (err_o[g])
        );

        assign grant[g]      = load && (sel_ch == CH_W'(g));
        assign accept_vec[g] = accept && (cmd_ch_o == CH_W'(g));
        assign cpl_vec[g]    = cpl_valid_i && (cpl_ch_i == CH_W'(g));
    end

    // rr_ptr_q is the first channel to consider, i.e. one past the last grant.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        idx       = 0;
        for (int i = 0; i < N_CH; i++) begin
            idx = (int'(rr_ptr_q) + i) % N_CH;
            if (!sel_found && elig[idx]) begin
                sel_found = 1'b1;
                sel_ch    = CH_W'(idx);
            end
        end
    end

    // Loading only into an empty register forces a bubble after every accept.
    assign load   = !cmd_valid_o && sel_found;
    assign accept = cmd_valid_o && cmd_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmd_valid_o <= 1'b0;
            cmd_ch_o    <= '0;
            cmd_addr_o  <= '0;
            cmd_len_o   <= '0;
            cmd_dir_o   <= DIR_READ;
            rr_ptr_q    <= '0;
        end else if (cke_i) begin
            if (load) begin
                cmd_valid_o <= 1'b1;
                cmd_ch_o    <= sel_ch;
                cmd_addr_o  <= ch_addr[sel_ch];
                cmd_len_o   <= ch_len[sel_ch];
                cmd_dir_o   <= ch_dir[sel_ch];
                rr_ptr_q    <= CH_W'((int'(sel_ch) + 1) % N_CH);
            end else if (accept) begin
                cmd_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_iob_dma_mc.sv
// Directed testbench for iob_dma_mc with DATA_W=32, BURST_W=4, MAX_OUTST=4.
module tb_iob_dma_mc;

    localparam int N_CH      = 4;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int LEN_W     = 24;
    localparam int BURST_W   = 4;
    localparam int MAX_OUTST = 4;
    localparam int CH_W      = 2;

    logic                   clk, cke_i, rst_i;
    logic [N_CH-1:0]        cfg_valid_i, cfg_ready_o, cfg_dir_i, abort_i;
    logic [N_CH*ADDR_W-1:0] cfg_addr_i;
    logic [N_CH*LEN_W-1:0]  cfg_len_i;
    logic                   cmd_valid_o, cmd_ready_i, cmd_dir_o;
    logic [CH_W-1:0]        cmd_ch_o, cpl_ch_i;
    logic [ADDR_W-1:0]      cmd_addr_o;
    logic [BURST_W-1:0]     cmd_len_o;
    logic                   cpl_valid_i, cpl_err_i;
    logic [N_CH-1:0]        busy_o, done_o, err_o;

    iob_dma_mc #(
        .N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
        .BURST_W(BURST_W), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk_i(clk), .cke_i(cke_i), .rst_i(rst_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
        .cfg_addr_i(cfg_addr_i), .cfg_len_i(cfg_len_i), .cfg_dir_i(cfg_dir_i),
        .abort_i(abort_i),
        .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_ch_o(cmd_ch_o),
        .cmd_addr_o(cmd_addr_o), .cmd_len_o(cmd_len_o), .cmd_dir_o(cmd_dir_o),
        .cpl_valid_i(cpl_valid_i), .cpl_ch_i(cpl_ch_i), .cpl_err_i(cpl_err_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    typedef struct { int ch; logic [31:0] addr; int len; } cmd_rec_t;
    typedef struct { int ch; int due; bit err; } cpl_rec_t;

    cmd_rec_t log_q[$];
    cpl_rec_t cpl_q[$];
    int       done_cnt[N_CH];
    bit       auto_cpl;
    int       cyc;
    int       n_checks, n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Records accepted commands and done pulses; schedules auto completions.
    initial begin
        cmd_rec_t r;
        cpl_rec_t c;
        forever begin
            @(negedge clk);
            if (!rst_i && cmd_valid_o && cmd_ready_i) begin
                r.ch = int'(cmd_ch_o);
                r.addr = cmd_addr_o;
                r.len = int'(cmd_len_o);
                log_q.push_back(r);
                if (auto_cpl) begin
                    c.ch = int'(cmd_ch_o);
                    c.due = cyc + 3;
                    c.err = 1'b0;
                    cpl_q.push_back(c);
                end
            end
            for (int i = 0; i < N_CH; i++)
                if (done_o[i]) done_cnt[i]++;
        end
    end

    // Completion driver, one completion per cycle at most.
    initial begin
        cpl_rec_t c;
        cpl_valid_i = 1'b0;
        cpl_ch_i = '0;
        cpl_err_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cpl_valid_i = 1'b0;
            cpl_err_i = 1'b0;
            if (cpl_q.size() > 0 && cpl_q[0].due <= cyc) begin
                c = cpl_q.pop_front();
                cpl_valid_i = 1'b1;
                cpl_ch_i = CH_W'(c.ch);
                cpl_err_i = c.err;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_desc(input int ch, input logic [31:0] addr, input int len, input bit dir);
        cfg_valid_i[ch] = 1'b1;
        cfg_addr_i[ch*ADDR_W +: ADDR_W] = addr;
        cfg_len_i[ch*LEN_W +: LEN_W] = LEN_W'(len);
        cfg_dir_i[ch] = dir;
    endtask

    task automatic release_cpl(input int ch, input bit err);
        cpl_rec_t c;
        c.ch = ch;
        c.due = 0;
        c.err = err;
        cpl_q.push_back(c);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        cfg_valid_i = '0;
        abort_i = '0;
        cmd_ready_i = 1'b1;
        auto_cpl = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        cpl_q.delete();
        log_q.delete();
        for (int i = 0; i < N_CH; i++) done_cnt[i] = 0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++;
        if (cfg_ready_o !== 4'hF) begin n_fail++; $display("FAIL reset_cfg_ready: got %h expected f", cfg_ready_o); end
        n_checks++;
        if (cmd_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid: got %b expected 0", cmd_valid_o); end
        n_checks++;
        if ({busy_o, done_o, err_o} !== 12'h000) begin n_fail++; $display("FAIL reset_status: got %h expected 000", {busy_o, done_o, err_o}); end
        n_checks++;
        if ({cmd_ch_o, cmd_addr_o, cmd_len_o, cmd_dir_o} !== 39'd0) begin
            n_fail++; $display("FAIL reset_cmd_fields: got %h expected 0", {cmd_ch_o, cmd_addr_o, cmd_len_o, cmd_dir_o});
        end
    endtask

    task automatic test_basic_split();
        logic [31:0] exp_addr[3];
        int exp_len[3];
        int k;
        exp_addr = '{32'h1000, 32'h1040, 32'h1080};
        exp_len = '{15, 15, 7};
        do_reset();
        auto_cpl = 1'b1;
        set_desc(0, 32'h1000, 40, 1'b0);
        tick();
        cfg_valid_i = '0;
        @(negedge clk);
        n_checks++;
        if (busy_o[0] !== 1'b1) begin n_fail++; $display("FAIL basic_busy_t1: got %b expected 1", busy_o[0]); end
        n_checks++;
        if (cmd_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_no_cmd_t1: got %b expected 0", cmd_valid_o); end
        tick();
        @(negedge clk);
        n_checks++;
        if ({cmd_valid_o, cmd_addr_o} !== {1'b1, 32'h1000}) begin
            n_fail++; $display("FAIL basic_first_cmd_t2: got valid %b addr %h expected 1 1000", cmd_valid_o, cmd_addr_o);
        end
        k = 0;
        while (done_cnt[0] == 0 && k < 100) begin tick(); k++; end
        n_checks++;
        if (done_cnt[0] == 0) begin n_fail++; $display("FAIL basic_done_timeout: got no done after %0d cycles expected 1 pulse", k); end
        repeat (5) tick();
        n_checks++;
        if (log_q.size() != 3) begin n_fail++; $display("FAIL basic_cmd_count: got %0d expected 3", log_q.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < log_q.size()) begin
                n_checks++;
                if (log_q[i].ch != 0 || log_q[i].addr !== exp_addr[i] || log_q[i].len != exp_len[i]) begin
                    n_fail++;
                    $display("FAIL basic_cmd%0d: got ch %0d addr %h len %0d expected ch 0 addr %h len %0d",
                             i, log_q[i].ch, log_q[i].addr, log_q[i].len, exp_addr[i], exp_len[i]);
                end
            end
        end
        n_checks++;
        if (done_cnt[0] != 1) begin n_fail++; $display("FAIL basic_done_once: got %0d expected 1", done_cnt[0]); end
        @(negedge clk);
        n_checks++;
        if ({err_o[0], busy_o[0], cfg_ready_o[0]} !== 3'b001) begin
            n_fail++; $display("FAIL basic_final_status: got err/busy/ready %b expected 001", {err_o[0], busy_o[0], cfg_ready_o[0]});
        end
    endtask

    task automatic test_boundary();
        int k;
        do_reset();
        auto_cpl = 1'b1;
        set_desc(1, 32'h0FF8, 10, 1'b1);
        tick();
        cfg_valid_i = '0;
        k = 0;
        while (done_cnt[1] == 0 && k < 100) begin tick(); k++; end
        n_checks++;
        if (done_cnt[1] == 0) begin n_fail++; $display("FAIL bound_done_timeout: got no done expected 1 pulse"); end
        repeat (3) tick();
        n_checks++;
        if (log_q.size() != 2) begin n_fail++; $display("FAIL bound_cmd_count: got %0d expected 2", log_q.size()); end
        if (log_q.size() >= 2) begin
            n_checks++;
            if (log_q[0].ch != 1 || log_q[0].addr !== 32'h0FF8 || log_q[0].len != 1) begin
                n_fail++; $display("FAIL bound_cmd0: got ch %0d addr %h len %0d expected 1 ff8 1", log_q[0].ch, log_q[0].addr, log_q[0].len);
            end
            n_checks++;
            if (log_q[1].ch != 1 || log_q[1].addr !== 32'h1000 || log_q[1].len != 7) begin
                n_fail++; $display("FAIL bound_cmd1: got ch %0d addr %h len %0d expected 1 1000 7", log_q[1].ch, log_q[1].addr, log_q[1].len);
            end
        end
        @(negedge clk);
        n_checks++;
        if (err_o[1] !== 1'b0) begin n_fail++; $display("FAIL bound_err: got %b expected 0", err_o[1]); end
    endtask

    task automatic test_round_robin();
        logic [31:0] ea;
        do_reset();
        set_desc(0, 32'h0000_0000, 128, 1'b0);
        set_desc(1, 32'h0000_8000, 128, 1'b0);
        tick();
        cfg_valid_i = '0;
        repeat (40) tick();
        n_checks++;
        if (log_q.size() != 8) begin n_fail++; $display("FAIL rr_cmd_count: got %0d expected 8", log_q.size()); end
        for (int i = 0; i < 8; i++) begin
            if (i < log_q.size()) begin
                ea = ((i % 2) == 1 ? 32'h8000 : 32'h0) + 32'(64 * (i / 2));
                n_checks++;
                if (log_q[i].ch != (i % 2) || log_q[i].addr !== ea || log_q[i].len != 15) begin
                    n_fail++;
                    $display("FAIL rr_cmd%0d: got ch %0d addr %h len %0d expected ch %0d addr %h len 15",
                             i, log_q[i].ch, log_q[i].addr, log_q[i].len, i % 2, ea);
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if ({cmd_valid_o, busy_o[1:0]} !== 3'b011) begin
            n_fail++; $display("FAIL rr_stall: got valid/busy %b expected 011", {cmd_valid_o, busy_o[1:0]});
        end
        release_cpl(1, 1'b0);
        repeat (20) tick();
        n_checks++;
        if (log_q.size() != 9) begin n_fail++; $display("FAIL rr_release_count: got %0d expected 9", log_q.size()); end
        if (log_q.size() >= 9) begin
            n_checks++;
            if (log_q[8].ch != 1 || log_q[8].addr !== 32'h8100) begin
                n_fail++; $display("FAIL rr_release_cmd: got ch %0d addr %h expected 1 8100", log_q[8].ch, log_q[8].addr);
            end
        end
    endtask

    task automatic test_zero_misaligned();
        do_reset();
        set_desc(2, 32'h4000, 0, 1'b0);
        tick();
        cfg_valid_i = '0;
        @(negedge clk);
        n_checks++;
        if ({done_o[2], busy_o[2], cfg_ready_o[2]} !== 3'b101) begin
            n_fail++; $display("FAIL zero_t1: got done/busy/ready %b expected 101", {done_o[2], busy_o[2], cfg_ready_o[2]});
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({done_o[2], busy_o[2]} !== 2'b00) begin n_fail++; $display("FAIL zero_t2: got done/busy %b expected 00", {done_o[2], busy_o[2]}); end
        set_desc(3, 32'h1002, 8, 1'b0);
        tick();
        cfg_valid_i = '0;
        @(negedge clk);
        n_checks++;
        if ({done_o[3], err_o[3], busy_o[3]} !== 3'b110) begin
            n_fail++; $display("FAIL misalign_t1: got done/err/busy %b expected 110", {done_o[3], err_o[3], busy_o[3]});
        end
        repeat (10) tick();
        n_checks++;
        if (log_q.size() != 0) begin n_fail++; $display("FAIL zero_misalign_no_cmd: got %0d cmds expected 0", log_q.size()); end
        n_checks++;
        if (done_cnt[2] != 1 || done_cnt[3] != 1) begin
            n_fail++; $display("FAIL zero_misalign_done_cnt: got %0d/%0d expected 1/1", done_cnt[2], done_cnt[3]);
        end
        @(negedge clk);
        n_checks++;
        if ({err_o[3], err_o[2]} !== 2'b10) begin n_fail++; $display("FAIL misalign_err_sticky: got %b expected 10", {err_o[3], err_o[2]}); end
    endtask

    task automatic test_abort();
        int k;
        do_reset();
        set_desc(2, 32'h2000, 64, 1'b0);
        tick();
        cfg_valid_i = '0;
        k = 0;
        while (log_q.size() == 0 && k < 50) begin tick(); k++; end
        n_checks++;
        if (log_q.size() != 1) begin n_fail++; $display("FAIL abort_first_cmd: got %0d cmds expected 1", log_q.size()); end
        abort_i[2] = 1'b1;
        tick();
        abort_i = '0;
        @(negedge clk);
        n_checks++;
        if ({busy_o[2], err_o[2], done_o[2]} !== 3'b110) begin
            n_fail++; $display("FAIL abort_drain: got busy/err/done %b expected 110", {busy_o[2], err_o[2], done_o[2]});
        end
        repeat (20) tick();
        @(negedge clk);
        n_checks++;
        if (log_q.size() != 1 || cmd_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL abort_no_more_cmds: got %0d cmds valid %b expected 1 0", log_q.size(), cmd_valid_o);
        end
        release_cpl(2, 1'b0);
        k = 0;
        while (done_cnt[2] == 0 && k < 20) begin tick(); k++; end
        n_checks++;
        if (done_cnt[2] != 1) begin n_fail++; $display("FAIL abort_done: got %0d pulses expected 1", done_cnt[2]); end
        repeat (3) tick();
        @(negedge clk);
        n_checks++;
        if ({err_o[2], busy_o[2]} !== 2'b10) begin n_fail++; $display("FAIL abort_final: got err/busy %b expected 10", {err_o[2], busy_o[2]}); end
    endtask

    task automatic test_backpressure_reset();
        do_reset();
        cmd_ready_i = 1'b0;
        set_desc(0, 32'h3000, 100, 1'b1);
        tick();
        cfg_valid_i = '0;
        tick();
        @(negedge clk);
        n_checks++;
        if (cmd_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_first_valid: got %b expected 1", cmd_valid_o); end
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            n_checks++;
            if ({cmd_valid_o, cmd_ch_o, cmd_addr_o, cmd_len_o, cmd_dir_o} !== {1'b1, 2'd0, 32'h3000, 4'd15, 1'b1}) begin
                n_fail++;
                $display("FAIL bp_stable%0d: got valid %b ch %0d addr %h len %0d dir %b expected 1 0 3000 15 1",
                         i, cmd_valid_o, cmd_ch_o, cmd_addr_o, cmd_len_o, cmd_dir_o);
            end
        end
        tick();
        rst_i = 1'b1;
        tick();
        @(negedge clk);
        n_checks++;
        if ({cmd_valid_o, busy_o, cfg_ready_o} !== 9'b0_0000_1111) begin
            n_fail++; $display("FAIL bp_reset: got valid %b busy %h ready %h expected 0 0 f", cmd_valid_o, busy_o, cfg_ready_o);
        end
        n_checks++;
        if (log_q.size() != 0) begin n_fail++; $display("FAIL bp_no_accept: got %0d cmds expected 0", log_q.size()); end
        tick();
        rst_i = 1'b0;
        cmd_ready_i = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        auto_cpl = 1'b0;
        cke_i = 1'b1;
        rst_i = 1'b1;
        cfg_valid_i = '0;
        cfg_addr_i = '0;
        cfg_len_i = '0;
        cfg_dir_i = '0;
        abort_i = '0;
        cmd_ready_i = 1'b1;
        test_reset();
        test_basic_split();
        test_boundary();
        test_round_robin();
        test_zero_misaligned();
        test_abort();
        test_backpressure_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
